cfg_tx_frame: RTL and testbench

Parametrised successor to the sensor configuration transmitter on SYS_CLOCK. It fetches a configuration frame from the conversion register file, serialises it onto the sensor's TX_DAT/TX_CLK/TX_OE_N lines and pulses TX_END on completion. Compared with the previous generation it adds:
- generic frame and word widths;
- LSB- or MSB-first ordering;
- a one-deep retransmit request queue;
- an abort input.

---
 rtl/cfg_tx_pkg.sv | 30 +++
 rtl/cfg_tx_bitclk.sv | 30 +++
 rtl/cfg_tx_frame.sv | 187 ++++++++++++++++++
 tb/tb_cfg_tx_frame.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_tx_pkg.sv
// Shared types and elaboration-time helpers for the SYS_CLOCK configuration transmitter.
package cfg_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_SHIFT_HI = 3'd4,
        ST_GUARD    = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    // Clock cycles per half bit period, rounded up so the bit is never shorter than asked.
    function automatic int calc_half(input int clk_ps, input int bit_ns);
        return (bit_ns * 1000 + 2 * clk_ps - 1) / (2 * clk_ps);
    endfunction

    function automatic int calc_nwords(input int nbits, input int word_w);
        return (nbits + word_w - 1) / word_w;
    endfunction

    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cfg_tx_bitclk.sv
// Half-period counter: strobes o_phase_end on the last cycle of each HALF-cycle phase while enabled.
module cfg_tx_bitclk
    import cfg_tx_pkg::*;
#(
    parameter int HALF = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_phase_end
);

    localparam int CW = clog2_min1(HALF);
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] r_cnt;

    assign o_phase_end = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_en || o_phase_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cfg_tx_frame.sv
// Fetches a configuration frame from the register file and serialises it on TX_DAT/TX_CLK/TX_OE_N.
module cfg_tx_frame
    import cfg_tx_pkg::*;
#(
    parameter int CLOCK_PERIOD_PS = 20833,
    parameter int BIT_PERIOD_NS   = 400,
    parameter int C_NO_CFG_BITS   = 24,
    parameter int C_WORD_W        = 16,
    parameter int C_ADDR_W        = 3,
    parameter int C_LSB_FIRST     = 0,
    parameter int C_GUARD_BITS    = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [C_WORD_W-1:0] i_input,
    output logic [C_ADDR_W-1:0] o_rd_addr,
    output logic                o_rd_en,
    output logic                o_tx_dat,
    output logic                o_tx_clk,
    output logic                o_tx_oe_n,
    output logic                o_tx_end,
    output logic                o_busy,
    output state_t              o_state
);

    localparam int HALF     = calc_half(CLOCK_PERIOD_PS, BIT_PERIOD_NS);
    localparam int NWORDS   = calc_nwords(C_NO_CFG_BITS, C_WORD_W);
    localparam int FRAME_W  = NWORDS * C_WORD_W;
    localparam int BIT_W    = clog2_min1(C_NO_CFG_BITS);
    localparam int GUARD_PH = 2 * C_GUARD_BITS;
    localparam int GW       = clog2_min1(GUARD_PH + 1);
    localparam logic [C_ADDR_W-1:0] LAST_WORD  = C_ADDR_W'(NWORDS - 1);
    localparam logic [BIT_W-1:0]    LAST_BIT   = BIT_W'(C_NO_CFG_BITS - 1);
    localparam logic [GW-1:0]       LAST_GUARD = GW'((GUARD_PH > 0) ? GUARD_PH - 1 : 0);

    state_t                r_state, w_state_nxt;
    logic [C_ADDR_W-1:0]   r_word, w_word_nxt;
    logic [BIT_W-1:0]      r_bit, w_bit_nxt, w_sel;
    logic [GW-1:0]         r_guard, w_guard_nxt;
    logic [FRAME_W-1:0]    r_frame, w_frame_nxt;
    logic [C_NO_CFG_BITS-1:0] w_frame_bits;
    logic [C_ADDR_W-1:0]   w_cap_idx;
    logic                  w_cap_en;
    logic                  r_pending, w_pending_nxt;
    logic                  w_phase_end, w_bitclk_en, w_shift;
    logic [C_ADDR_W-1:0]   r_rd_addr, w_rd_addr_nxt;
    logic                  r_rd_en, r_tx_dat, r_tx_clk, r_tx_oe_n, r_tx_end, r_busy;
    logic                  w_rd_en_nxt, w_tx_dat_nxt, w_tx_clk_nxt, w_tx_oe_n_nxt, w_tx_end_nxt, w_busy_nxt;

    assign w_bitclk_en = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI) || (r_state == ST_GUARD);

    cfg_tx_bitclk #(.HALF(HALF)) u_bitclk (
        .i_clk       (i_clock),
        .i_rst       (i_reset),
        .i_en        (w_bitclk_en),
        .o_phase_end (w_phase_end)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_word    <= '0;
            r_bit     <= '0;
            r_guard   <= '0;
            r_frame   <= '0;
            r_pending <= 1'b0;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b0;
            r_tx_dat  <= 1'b0;
            r_tx_clk  <= 1'b0;
            r_tx_oe_n <= 1'b1;
            r_tx_end  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_word    <= w_word_nxt;
            r_bit     <= w_bit_nxt;
            r_guard   <= w_guard_nxt;
            r_frame   <= w_frame_nxt;
            r_pending <= w_pending_nxt;
            r_rd_addr <= w_rd_addr_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_tx_dat  <= w_tx_dat_nxt;
            r_tx_clk  <= w_tx_clk_nxt;
            r_tx_oe_n <= w_tx_oe_n_nxt;
            r_tx_end  <= w_tx_end_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_word_nxt    = r_word;
        w_bit_nxt     = r_bit;
        w_guard_nxt   = r_guard;
        w_pending_nxt = r_pending;
        if (i_start && (r_state != ST_IDLE)) w_pending_nxt = 1'b1;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nxt = ST_FETCH;
                    w_word_nxt  = '0;
                end
            end
            ST_FETCH: begin
                if (r_word == LAST_WORD) w_state_nxt = ST_LOAD;
                else w_word_nxt = r_word + C_ADDR_W'(1);
            end
            ST_LOAD: begin
                w_state_nxt = ST_SHIFT_LO;
                w_bit_nxt   = '0;
            end
            ST_SHIFT_LO: begin
                if (w_phase_end) w_state_nxt = ST_SHIFT_HI;
            end
            ST_SHIFT_HI: begin
                if (w_phase_end) begin
                    if (r_bit == LAST_BIT) begin
                        w_state_nxt = (C_GUARD_BITS == 0) ? ST_DONE : ST_GUARD;
                        w_guard_nxt = '0;
                    end else begin
                        w_state_nxt = ST_SHIFT_LO;
                        w_bit_nxt   = r_bit + BIT_W'(1);
                    end
                end
            end
            ST_GUARD: begin
                if (w_phase_end) begin
                    if (r_guard == LAST_GUARD) w_state_nxt = ST_DONE;
                    else w_guard_nxt = r_guard + GW'(1);
                end
            end
            ST_DONE: begin
                // A START landing in this very cycle still counts as a retransmit request.
                w_pending_nxt = 1'b0;
                if (r_pending || i_start) begin
                    w_state_nxt = ST_FETCH;
                    w_word_nxt  = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (i_abort && (r_state != ST_IDLE)) begin
            w_state_nxt   = ST_IDLE;
            w_pending_nxt = 1'b0;
        end
    end

    // INPUT lags RD_EN by one cycle, so FETCH cycle k stores word k-1 and LOAD stores the last word.
    always_comb begin
        w_cap_en    = ((r_state == ST_FETCH) && (r_word != '0)) || (r_state == ST_LOAD);
        w_cap_idx   = (r_state == ST_LOAD) ? LAST_WORD : (r_word - C_ADDR_W'(1));
        w_frame_nxt = r_frame;
        for (int i = 0; i < NWORDS; i++) begin
            if (w_cap_en && (w_cap_idx == C_ADDR_W'(i))) w_frame_nxt[i*C_WORD_W +: C_WORD_W] = i_input;
        end
    end

    assign w_frame_bits = w_frame_nxt[C_NO_CFG_BITS-1:0];

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        w_shift       = (w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI);
        w_sel         = (C_LSB_FIRST != 0) ? w_bit_nxt : (LAST_BIT - w_bit_nxt);
        w_rd_en_nxt   = (w_state_nxt == ST_FETCH);
        w_rd_addr_nxt = w_rd_en_nxt ? w_word_nxt : '0;
        w_tx_dat_nxt  = w_shift && w_frame_bits[w_sel];
        w_tx_clk_nxt  = (w_state_nxt == ST_SHIFT_HI);
        w_tx_oe_n_nxt = !w_shift;
        w_tx_end_nxt  = (w_state_nxt == ST_DONE);
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
    end

    assign o_rd_addr = r_rd_addr;
    assign o_rd_en   = r_rd_en;
    assign o_tx_dat  = r_tx_dat;
    assign o_tx_clk  = r_tx_clk;
    assign o_tx_oe_n = r_tx_oe_n;
    assign o_tx_end  = r_tx_end;
    assign o_busy    = r_busy;
    assign o_state   = r_state;

endmodule

// File: tb/tb_cfg_tx_frame.sv
// Directed bench for cfg_tx_frame: default, LSB-first and single-word instances run side by side.
`timescale 1ns/1ps
module tb_cfg_tx_frame;
    import cfg_tx_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    always #10 clk = ~clk;

    logic [15:0] mem [8];
    logic [15:0] din [3];
    logic [2:0]  rd_addr [3];
    logic        rd_en [3], tx_dat [3], tx_clk [3], tx_oe_n [3], tx_end [3], busy [3];
    state_t      st [3];

    int total = 0;
    int bad = 0;

    cfg_tx_frame dut_msb (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort), .i_input(din[0]),
        .o_rd_addr(rd_addr[0]), .o_rd_en(rd_en[0]), .o_tx_dat(tx_dat[0]), .o_tx_clk(tx_clk[0]),
        .o_tx_oe_n(tx_oe_n[0]), .o_tx_end(tx_end[0]), .o_busy(busy[0]), .o_state(st[0]));

    cfg_tx_frame #(.C_LSB_FIRST(1)) dut_lsb (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort), .i_input(din[1]),
        .o_rd_addr(rd_addr[1]), .o_rd_en(rd_en[1]), .o_tx_dat(tx_dat[1]), .o_tx_clk(tx_clk[1]),
        .o_tx_oe_n(tx_oe_n[1]), .o_tx_end(tx_end[1]), .o_busy(busy[1]), .o_state(st[1]));

    cfg_tx_frame #(.C_NO_CFG_BITS(16)) dut_w16 (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort), .i_input(din[2]),
        .o_rd_addr(rd_addr[2]), .o_rd_en(rd_en[2]), .o_tx_dat(tx_dat[2]), .o_tx_clk(tx_clk[2]),
        .o_tx_oe_n(tx_oe_n[2]), .o_tx_end(tx_end[2]), .o_busy(busy[2]), .o_state(st[2]));

    // Register file model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rd_en[i]) din[i] <= mem[rd_addr[i]];
        end
    end

    logic        mon_clr = 1'b0;
    int          cyc = 0;
    int          rises [3], ends [3], rdens [3], bad_addr [3], oe_low [3], restart_ok [3];
    int          oe_fall_cyc [3], busy_rise_cyc [3], end_cyc [3];
    logic [31:0] sh [3];
    logic        prev_clk [3], prev_oe [3], prev_busy [3], prev_end [3];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) begin
            prev_clk[i]  <= tx_clk[i];
            prev_oe[i]   <= tx_oe_n[i];
            prev_busy[i] <= busy[i];
            prev_end[i]  <= tx_end[i];
            if (mon_clr) begin
                rises[i] <= 0; ends[i] <= 0; rdens[i] <= 0; bad_addr[i] <= 0;
                oe_low[i] <= 0; restart_ok[i] <= 0; sh[i] <= '0;
            end else begin
                if (tx_clk[i] && !prev_clk[i]) begin
                    rises[i] <= rises[i] + 1;
                    sh[i]    <= {sh[i][30:0], tx_dat[i]};
                end
                if (tx_end[i]) begin
                    ends[i]    <= ends[i] + 1;
                    end_cyc[i] <= cyc;
                end
                if (rd_en[i]) begin
                    rdens[i] <= rdens[i] + 1;
                    if (int'(rd_addr[i]) >= ((i == 2) ? 1 : 2)) bad_addr[i] <= bad_addr[i] + 1;
                    if (prev_end[i]) restart_ok[i] <= restart_ok[i] + 1;
                end
                if (!tx_oe_n[i]) oe_low[i] <= oe_low[i] + 1;
                if (!tx_oe_n[i] && prev_oe[i]) oe_fall_cyc[i] <= cyc;
                if (busy[i] && !prev_busy[i]) busy_rise_cyc[i] <= cyc;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic clear_mon();
        @(posedge clk); mon_clr = 1'b1;
        @(posedge clk); mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_rises(input int n, input int budget);
        int k;
        k = 0;
        while (rises[0] < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_rises", 32'(rises[0] >= n), 1);
    endtask

    task automatic wait_ends(input int n, input int budget);
        int k;
        k = 0;
        while (ends[0] < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("wait_ends", 32'(ends[0] >= n), 1);
    endtask

    initial begin
        for (int a = 0; a < 8; a++) mem[a] = 16'h0000;
        mem[0] = 16'hC30F;
        mem[1] = 16'h00A5;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_busy", busy[0], 0);
        check("rst_oe_n", tx_oe_n[0], 1);
        check("rst_tx_clk", tx_clk[0], 0);
        check("rst_tx_dat", tx_dat[0], 0);
        check("rst_tx_end", tx_end[0], 0);
        check("rst_rd_en", rd_en[0], 0);
        check("rst_rd_addr", rd_addr[0], 0);
        check("rst_state", st[0], ST_IDLE);
        rst = 1'b0;

        // Basic frame on all three instances
        clear_mon();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy[0], 1);
        check("start_rd_en", rd_en[0], 1);
        check("start_rd_addr", rd_addr[0], 0);
        wait_ends(1, 800);
        repeat (5) @(negedge clk);
        check("msb_bits", sh[0][23:0], 24'hA5C30F);
        check("msb_rises", rises[0], 24);
        check("msb_ends", ends[0], 1);
        check("msb_frame_len", end_cyc[0] - oe_fall_cyc[0], 520);
        check("msb_oe_delay", oe_fall_cyc[0] - busy_rise_cyc[0], 3);
        check("msb_rdens", rdens[0], 2);
        check("msb_bad_addr", bad_addr[0], 0);
        check("msb_oe_low", oe_low[0], 480);
        check("lsb_bits", sh[1][23:0], 24'hF0C3A5);
        check("lsb_rises", rises[1], 24);
        check("w16_rdens", rdens[2], 1);
        check("w16_bad_addr", bad_addr[2], 0);
        check("w16_oe_low", oe_low[2], 320);
        check("w16_rises", rises[2], 16);
        check("w16_bits", sh[2][15:0], 16'hC30F);
        check("w16_frame_len", end_cyc[2] - oe_fall_cyc[2], 360);
        check("w16_oe_delay", oe_fall_cyc[2] - busy_rise_cyc[2], 2);
        check("idle_after_frame", busy[0], 0);

        // Retransmit request at bit 5, dropped duplicate at bit 10, register update between frames
        clear_mon();
        pulse_start();
        wait_rises(5, 300);
        pulse_start();
        mem[0] = 16'h1234;
        wait_rises(10, 300);
        pulse_start();
        wait_ends(2, 1500);
        repeat (50) @(negedge clk);
        check("rtx_ends", ends[0], 2);
        check("rtx_rises", rises[0], 48);
        check("rtx_bits2", sh[0][23:0], 24'hA51234);
        check("rtx_rdens", rdens[0], 4);
        check("rtx_restart", restart_ok[0], 1);
        check("rtx_idle", busy[0], 0);

        // Abort at bit 12 with a retransmit pending
        clear_mon();
        pulse_start();
        wait_rises(10, 300);
        pulse_start();
        wait_rises(12, 100);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_oe_n", tx_oe_n[0], 1);
        check("abort_tx_clk", tx_clk[0], 0);
        check("abort_tx_dat", tx_dat[0], 0);
        check("abort_busy", busy[0], 0);
        repeat (700) @(negedge clk);
        check("abort_no_end", ends[0], 0);
        check("abort_no_refetch", rdens[0], 2);
        check("abort_still_idle", busy[0], 0);

        // START and ABORT together while idle
        clear_mon();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("sa_busy", busy[0], 0);
        check("sa_rd_en", rd_en[0], 0);
        repeat (10) @(negedge clk);
        check("sa_no_reads", rdens[0], 0);
        check("sa_state", st[0], ST_IDLE);

        // Asynchronous reset in the middle of SHIFT_HI, then a fresh frame
        clear_mon();
        pulse_start();
        wait_rises(3, 300);
        check("pre_rst_clk_high", tx_clk[0], 1);
        #3 rst = 1'b1;
        #1;
        check("arst_oe_n", tx_oe_n[0], 1);
        check("arst_tx_clk", tx_clk[0], 0);
        check("arst_tx_dat", tx_dat[0], 0);
        check("arst_busy", busy[0], 0);
        check("arst_state", st[0], ST_IDLE);
        @(negedge clk); rst = 1'b0;
        mem[0] = 16'hC30F;
        clear_mon();
        pulse_start();
        wait_ends(1, 800);
        repeat (5) @(negedge clk);
        check("post_rst_bits", sh[0][23:0], 24'hA5C30F);
        check("post_rst_rises", rises[0], 24);
        check("post_rst_ends", ends[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
